// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared constants and helpers for the programmable serial
//               pattern detector.
//               - DEFAULT_PAT : pattern loaded at reset (12 bits)
//               - PAT_W_MIN / PAT_W_MAX : supported pattern length range
//               - fill_width(): bits needed to count 0..pat_w accepted bits
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int                         DEFAULT_PAT_W = 12;
    localparam logic [DEFAULT_PAT_W-1:0]   DEFAULT_PAT   = 12'b1110_1101_1011;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;

    // Width of a counter that must represent every value 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up counter that sticks at all ones. clr has priority over inc.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-low reset (count -> 0)
//               clr   - synchronous clear
//               inc   - increment request (ignored when saturated)
//               count - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_prog
// Description : Programmable serial pattern detector. Shifts valid-qualified
//               bits into a PAT_W history and compares it against a loadable
//               pattern with a per-bit care mask. Supports overlapping and
//               non-overlapping detection and counts matches (saturating).
// Ports       : clk       - rising-edge clock
//               reset     - asynchronous active-low reset
//               valid_i   - x_i carries a stream bit this cycle
//               x_i       - serial bit (first received lands at pattern MSB)
//               load_i    - latch pattern_i/care_i and restart detection
//               pattern_i - pattern to load
//               care_i    - 1 = compare bit, 0 = don't care
//               overlap_i - 1 = overlapping, 0 = non-overlapping detection
//               det_o     - registered one-cycle match pulse
//               count_o   - saturating match count
//               armed_o   - PAT_W bits accepted since the last restart
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_prog
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 12,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEFAULT_PAT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             x_i,
    input  logic             load_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [PAT_W-1:0] care_i,
    input  logic             overlap_i,
    output logic             det_o,
    output logic [CNT_W-1:0] count_o,
    output logic             armed_o
);

    localparam int             FW   = fill_width(PAT_W);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);

    logic [PAT_W-1:0] hist_q;
    logic [FW-1:0]    fill_q;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] care_q;
    logic             det_q;

    logic [PAT_W-1:0] hist_n;
    logic [FW-1:0]    fill_n;
    logic             match;

    // Candidate next history/fill if the current bit is accepted; match only
    // once a full window of bits since the last restart is present.
    always_comb begin
        hist_n = {hist_q[PAT_W-2:0], x_i};
        fill_n = (fill_q == FULL) ? FULL : fill_q + FW'(1);
        match  = (fill_n == FULL) && (((hist_n ^ pat_q) & care_q) == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= RST_PAT;
            care_q <= '1;
            det_q  <= 1'b0;
        end else if (load_i) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= pattern_i;
            care_q <= care_i;
            det_q  <= 1'b0;
        end else if (valid_i) begin
            hist_q <= hist_n;
            det_q  <= match;
            // Non-overlapping: the matched bits are consumed, so the next
            // match needs a completely fresh window.
            if (match && !overlap_i) begin
                fill_q <= '0;
            end else begin
                fill_q <= fill_n;
            end
        end else begin
            det_q <= 1'b0;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_count (
        .clk   (clk),
        .reset (reset),
        .clr   (load_i),
        .inc   (valid_i && !load_i && match),
        .count (count_o)
    );

    assign det_o   = det_q;
    assign armed_o = (fill_q == FULL);

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_prog
// Description : Self-checking bench for seq_detect_prog. Two instances:
//               u_dut0 with defaults (PAT_W=12, CNT_W=8) and u_dut1 with
//               PAT_W=4, CNT_W=2. A driver issues one step per clock and
//               pushes the expected outputs into a scoreboard queue; a monitor
//               pops and compares after every active edge. The reference
//               model keeps the list of accepted bits since the last restart.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_prog;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0 : defaults ----------------
    logic        valid0 = 0, x0 = 0, load0 = 0, ov0 = 0;
    logic [11:0] pat0 = '0, care0 = '0;
    logic        det0, armed0;
    logic [7:0]  count0;

    seq_detect_prog u_dut0 (
        .clk(clk), .reset(rst_n), .valid_i(valid0), .x_i(x0), .load_i(load0),
        .pattern_i(pat0), .care_i(care0), .overlap_i(ov0),
        .det_o(det0), .count_o(count0), .armed_o(armed0)
    );

    // ---------------- DUT 1 : PAT_W=4, CNT_W=2 ----------------
    logic        valid1 = 0, x1 = 0, load1 = 0, ov1 = 0;
    logic [3:0]  pat1 = '0, care1 = '0;
    logic        det1, armed1;
    logic [1:0]  count1;

    seq_detect_prog #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1001)) u_dut1 (
        .clk(clk), .reset(rst_n), .valid_i(valid1), .x_i(x1), .load_i(load1),
        .pattern_i(pat1), .care_i(care1), .overlap_i(ov1),
        .det_o(det1), .count_o(count1), .armed_o(armed1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       d;
        logic       det;
        logic [7:0] cnt;
        logic       armed;
    } exp_t;

    exp_t sb[$];

    // ---------------- reference model state ----------------
    bit          q0[$];       // accepted bits since restart, oldest first
    bit          q1[$];
    logic [31:0] mp [2];
    logic [31:0] mc [2];
    int          mcnt [2];

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        mp[0] = 32'hEDB; mc[0] = 32'hFFF; mcnt[0] = 0;
        mp[1] = 32'h9;   mc[1] = 32'hF;   mcnt[1] = 0;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // One clock of stimulus on DUT d; the other DUT is held idle.
    task automatic step(input int d, input bit v, input bit x, input bit ld,
                        input bit ov, input logic [31:0] p = 0,
                        input logic [31:0] c = 0);
        bit   h[$];
        int   w, cmax;
        bit   det, ok;
        exp_t e;
        @(negedge clk);
        if (d == 0) begin
            valid0 = v; x0 = x; load0 = ld; ov0 = ov; pat0 = p[11:0]; care0 = c[11:0];
            valid1 = 0; load1 = 0;
            h = q0; w = 12; cmax = 255;
        end else begin
            valid1 = v; x1 = x; load1 = ld; ov1 = ov; pat1 = p[3:0]; care1 = c[3:0];
            valid0 = 0; load0 = 0;
            h = q1; w = 4; cmax = 3;
        end
        det = 0;
        if (ld) begin
            mp[d] = p; mc[d] = c; mcnt[d] = 0;
            h.delete();
        end else if (v) begin
            h.push_back(x);
            if (h.size() > w) void'(h.pop_front());
            if (h.size() == w) begin
                ok = 1;
                for (int i = 0; i < w; i++)
                    if (mc[d][w-1-i] && (h[i] != mp[d][w-1-i])) ok = 0;
                det = ok;
            end
            if (det && mcnt[d] < cmax) mcnt[d]++;
            if (det && !ov) h.delete();
        end
        if (d == 0) q0 = h; else q1 = h;
        e.d     = d[0];
        e.det   = det;
        e.cnt   = 8'(mcnt[d]);
        e.armed = (h.size() == w);
        sb.push_back(e);
        @(posedge clk);
    endtask

    // ---------------- monitor ----------------
    exp_t me;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            me = sb.pop_front();
            if (me.d == 1'b0) begin
                chk("det0",   int'(det0),   int'(me.det));
                chk("count0", int'(count0), int'(me.cnt));
                chk("armed0", int'(armed0), int'(me.armed));
            end else begin
                chk("det1",   int'(det1),   int'(me.det));
                chk("count1", int'(count1), int'(me.cnt));
                chk("armed1", int'(armed1), int'(me.armed));
            end
        end
    end

    initial begin
        logic [11:0] s12;
        logic [7:0]  s8;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_det0", int'(det0), 0);
        chk("rst_count0", int'(count0), 0);
        chk("rst_armed0", int'(armed0), 0);
        chk("rst_armed1", int'(armed1), 0);
        rst_n = 1'b1;

        // Default pattern straight after reset
        s12 = 12'b1110_1101_1011;
        for (int i = 11; i >= 0; i--) step(0, 1, s12[i], 0, 1);
        #2;
        chk("tp1_det", int'(det0), 1);
        chk("tp1_count", int'(count0), 1);
        step(0, 0, 0, 0, 1);
        #2;
        chk("tp1_det_pulse", int'(det0), 0);

        // Gaps after bit 6 stretch the sequence
        step(0, 0, 0, 1, 1, 32'hEDB, 32'hFFF);
        for (int i = 11; i >= 6; i--) step(0, 1, s12[i], 0, 1);
        repeat (3) step(0, 0, 1, 0, 1);
        for (int i = 5; i >= 0; i--) step(0, 1, s12[i], 0, 1);
        #2;
        chk("gap_det", int'(det0), 1);

        // PAT_W=4, 1010, overlap / non-overlap
        step(1, 0, 0, 1, 1, 32'hA, 32'hF);
        for (int i = 0; i < 6; i++) step(1, 1, (i % 2 == 0), 0, 1);
        #2;
        chk("ov_count", int'(count1), 2);
        step(1, 0, 0, 1, 0, 32'hA, 32'hF);
        for (int i = 0; i < 6; i++) step(1, 1, (i % 2 == 0), 0, 0);
        #2;
        chk("nov_count", int'(count1), 1);
        step(1, 0, 0, 1, 0, 32'hA, 32'hF);
        s8 = 8'b1010_1010;
        for (int i = 7; i >= 0; i--) step(1, 1, s8[i], 0, 0);
        #2;
        chk("nov8_count", int'(count1), 2);

        // Care mask 0110 on pattern 1111
        step(1, 0, 0, 1, 1, 32'hF, 32'h6);
        step(1, 1, 0, 0, 1); step(1, 1, 1, 0, 1); step(1, 1, 1, 0, 1); step(1, 1, 0, 0, 1);
        #2;
        chk("care_hit", int'(det1), 1);
        step(1, 0, 0, 1, 1, 32'hF, 32'h6);
        step(1, 1, 0, 0, 1); step(1, 1, 1, 0, 1); step(1, 1, 0, 0, 1); step(1, 1, 0, 0, 1);
        #2;
        chk("care_miss", int'(det1), 0);

        // Saturation with CNT_W=2
        step(1, 0, 0, 1, 1, 32'hF, 32'hF);
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 1);
        #2;
        chk("sat_count", int'(count1), 3);
        step(1, 0, 0, 1, 1, 32'hF, 32'hF);
        #2;
        chk("load_count", int'(count1), 0);
        chk("load_armed", int'(armed1), 0);

        // Asynchronous reset after bit 11
        step(0, 0, 0, 1, 1, 32'hEDB, 32'hFFF);
        for (int i = 11; i >= 1; i--) step(0, 1, s12[i], 0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_det", int'(det0), 0);
        chk("arst_count", int'(count0), 0);
        chk("arst_armed", int'(armed0), 0);
        model_reset();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        #2;
        rst_n = 1'b1;
        step(0, 1, s12[0], 0, 1);
        #2;
        chk("arst_nodet", int'(det0), 0);

        // Randomised traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            int   d;
            bit   ld;
            logic [31:0] p, c;
            d  = int'($urandom_range(0, 1));
            ld = ($urandom_range(0, 60) == 0);
            p  = $urandom;
            c  = (d == 0) ? ($urandom & $urandom & $urandom) : $urandom;
            step(d, ($urandom_range(0, 3) != 0), 1'($urandom), ld,
                 1'($urandom), p, c);
        end

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detect_prog.md
# seq_detect_prog

Parametrised serial pattern detector: the programmable successor to the team's fixed 12-bit sequence detector.
- Watches a serial bit stream and compares the last PAT_W accepted bits against a runtime-loadable pattern with per-bit don't-care mask.
- Selectable overlapping or non-overlapping detection; counts matches with a saturating counter.
- Sits between a serial front end (valid-qualified bit stream) and status/interrupt logic.

## Interface
- PAT_W, 12, pattern length in bits (2..32)
- CNT_W, 8, match counter width (>=1)
- RST_PAT, 12'b1110_1101_1011, pattern loaded at reset (width PAT_W)
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-low
- valid_i  input  1  x_i is a valid stream bit this cycle
- x_i  input  1  serial data bit, first-received bit ends up at pattern MSB
- load_i  input  1  latch pattern_i/care_i, restart detection
- pattern_i  input  PAT_W  pattern to load
- care_i  input  PAT_W  1 = compare bit, 0 = don't care
- overlap_i  input  1  1 = overlapping, 0 = non-overlapping (sampled every cycle)
- det_o  output  1  one-cycle match pulse, registered
- count_o  output  CNT_W  saturating match count
- armed_o  output  1  history holds >= PAT_W bits since last restart

## Operation
- Registers: hist_q[PAT_W], fill_q (0..PAT_W), pat_q, care_q, count_q, det_q.
- Reset (reset=0, async): hist_q=0, fill_q=0, pat_q=RST_PAT, care_q=all ones, count_o=0, det_o=0, armed_o=0.
- Priority per edge: load_i > valid_i > idle.
- load_i=1: pat_q<=pattern_i, care_q<=care_i, hist_q<=0, fill_q<=0, count_q<=0, det_o<=0; x_i that cycle discarded even if valid_i=1.
- valid_i=1, load_i=0: hist_n={hist_q[PAT_W-2:0],x_i}; fill_n=min(fill_q+1,PAT_W); match=(fill_n==PAT_W) && (((hist_n^pat_q)&care_q)==0).
  - hist_q<=hist_n; det_o<=match; count_q<=count_q+1 if match and count_q != all ones.
  - match && overlap_i=0: fill_q<=0 (the matched bits cannot contribute to the next match); else fill_q<=fill_n.
- valid_i=0: hist_q, fill_q, count_q hold; det_o<=0.
- care_i=0 (all don't care): matches on every valid bit once filled (every PAT_W bits in non-overlap mode).
- armed_o = (fill_q==PAT_W), combinational from register.
- Changing overlap_i mid-stream takes effect on the next accepted bit; no restart.

## Timing
- Latency: det_o high the cycle after the edge that samples the final pattern bit; count_o updates on that same edge.
- det_o is never high for two consecutive cycles in non-overlap mode when PAT_W>1; in overlap mode it may be high on consecutive valid bits (e.g. pattern all ones).
- Earliest detection: PAT_W-th accepted bit after reset or load.
- Reset asserted mid-stream: all state cleared immediately, det_o drops without waiting for clk.
- Gaps in valid_i stretch, but do not break, a sequence.

## Structure
- Shared package seq_det_pkg: default pattern constant, SAT helper width constants.
- Sub-module sat_counter (param W; inc, clr; saturates at all ones) for count_q; everything else in one module.
- No FSM enum needed; fill_q acts as FILLING/ARMED state.

## Test plan
- Default pattern, stream 1,1,1,0,1,1,0,1,1,0,1,1 after reset -> det_o=1 exactly one cycle after 12th bit, count_o=1, armed_o=1.
- PAT_W=4 load 1010/care 1111, overlap_i=1, stream 1,0,1,0,1,0 -> det_o after bits 4 and 6, count_o=2; overlap_i=0 same stream -> only bit 4, count_o=1; stream 10101010 non-overlap -> bits 4 and 8.
- PAT_W=4 pattern 1111 care 0110, stream 0,1,1,0 -> det_o=1; stream 0,1,0,0 -> no detect.
- Default pattern with valid_i=0 for 3 cycles inserted after bit 6 -> detect still fires after bit 12, det_o low during gaps.
- CNT_W=2, PAT_W=4 pattern 1111 overlap, 8 ones -> detects on bits 4..8 (5 pulses), count_o=3 saturated; load_i -> count_o=0, armed_o=0.
- Reset asserted asynchronously between edges after bit 11 -> det_o/count_o/armed_o=0 immediately; bit 12 after release gives no detect.
